// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF pipeline register, JMP resolution and self-jump halt.
// Latency: one cycle from Address_out to IF_Instruction/IF_PC4/IF_Valid; JMP resolves with no bubble.
// Backpressure: Stall freezes PC, IF outputs, counter and state; Branch_taken overrides Stall and squashes IF.
module fetch_unit #(
    parameter logic [31:0] RESET_PC         = 32'd0,
    parameter bit          HALT_ON_SELFJUMP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_target,
    input  logic [31:0] Instruction,
    output logic [31:0] Address_out,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PC4,
    output logic        IF_Valid,
    output logic        Halted,
    output logic [15:0] Fetch_count
);

    localparam logic [5:0] OP_JMP = 6'b101010;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [15:0] imm;
    logic        is_jmp;
    logic        is_selfjump;
    logic        fetch_go;
    logic [31:0] pc_seq;
    logic [31:0] jmp_target;
    logic [31:0] redirect_pc;

    // Instruction decode and PC arithmetic (all modulo 2^32)
    assign opcode      = Instruction[31:26];
    assign imm         = Instruction[15:0];
    assign is_jmp      = (opcode == OP_JMP);
    assign is_selfjump = is_jmp && (imm == 16'hFFFF) && HALT_ON_SELFJUMP;
    assign pc_seq      = pc + 32'd4;
    assign jmp_target  = pc_seq + {{14{imm[15]}}, imm, 2'b00};
    assign redirect_pc = Branch_target & 32'hFFFF_FFFC;
    assign fetch_go    = (state == RUN) && !Branch_taken && !Stall;
    assign Address_out = pc;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: redirect always resumes, a self-jump in RUN parks the fetcher
    always_comb begin
        state_nxt = state;
        if (Branch_taken) begin
            state_nxt = RUN;
        end else if (Stall) begin
            state_nxt = state;
        end else if ((state == RUN) && is_selfjump) begin
            state_nxt = HALT;
        end
    end

    // FSM outputs
    always_comb begin
        Halted = (state == HALT);
    end

    // PC, IF register and issue counter with priority rst > redirect > stall > fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            IF_Instruction <= 32'd0;
            IF_PC4         <= 32'd0;
            IF_Valid       <= 1'b0;
            Fetch_count    <= 16'd0;
        end else if (Branch_taken) begin
            pc             <= redirect_pc;
            IF_Instruction <= 32'd0;
            IF_Valid       <= 1'b0;
        end else if (Stall) begin
            pc             <= pc;
        end else if (state == HALT) begin
            // Halted: PC parked on the self-jump, last issued word stays visible but not live
            IF_Valid       <= 1'b0;
        end else if (fetch_go) begin
            IF_Instruction <= Instruction;
            IF_PC4         <= pc_seq;
            IF_Valid       <= 1'b1;
            if (Fetch_count != 16'hFFFF) begin
                Fetch_count <= Fetch_count + 16'd1;
            end
            if (is_selfjump) begin
                pc <= pc;
            end else if (is_jmp) begin
                pc <= jmp_target;
            end else begin
                pc <= pc_seq;
            end
        end
    end

endmodule
